// File: rtl/life_tracker_pkg.sv
// Shared game definitions: state encoding, life counter width and the
// saturating life increment used by the tracker.
package life_tracker_pkg;

  localparam int LIFE_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    INVULN    = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  function automatic logic [LIFE_W-1:0] sat_inc(input logic [LIFE_W-1:0] v,
                                                input logic [LIFE_W-1:0] ceil_v);
    logic [LIFE_W-1:0] res;
    if (v >= ceil_v) begin
      res = ceil_v;
    end else begin
      res = v + LIFE_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/life_tracker_if.sv
// Player-event inputs and display-facing outputs of the life tracker.
interface life_tracker_if;
  import life_tracker_pkg::*;

  logic              start;
  logic              hit;
  logic              bonus;
  logic [LIFE_W-1:0] life;
  logic              game_over;
  logic              invulnerable;
  logic              blink;

  modport master (output start, hit, bonus,
                  input  life, game_over, invulnerable, blink);
  modport slave  (input  start, hit, bonus,
                  output life, game_over, invulnerable, blink);
endinterface

// File: rtl/life_tracker_rise_edge.sv
// Rising-edge detector for a level request; a level already high when reset
// is released must be seen low once before it can produce a pulse.
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;
  logic r_armed;

  // Previous-level copy plus the seen-low qualifier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_level;
      r_armed <= r_armed | ~i_level;
    end
  end

  assign o_pulse = i_level & ~r_prev & r_armed;

endmodule

// File: rtl/life_tracker.sv
// Player life tracker: start/hit/bonus edges drive a four-state game FSM with
// a timed invulnerability window and a blinking display request.
module life_tracker
  import life_tracker_pkg::*;
#(
  parameter int INIT_LIFE     = 3,
  parameter int MAX_LIFE      = 9,
  parameter int INVULN_CYCLES = 50_000_000,
  parameter int BLINK_HALF    = 6_250_000
) (
  input  logic           clk,
  input  logic           rst,
  life_tracker_if.slave  bus
);

  localparam int TIMER_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(INVULN_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [LIFE_W-1:0]  LIFE_INIT  = LIFE_W'(INIT_LIFE);
  localparam logic [LIFE_W-1:0]  LIFE_CEIL  = LIFE_W'(MAX_LIFE);

  logic w_start;
  logic w_hit;
  logic w_bonus;

  rise_edge u_start_edge (.clk(clk), .rst(rst), .i_level(bus.start), .o_pulse(w_start));
  rise_edge u_hit_edge   (.clk(clk), .rst(rst), .i_level(bus.hit),   .o_pulse(w_hit));
  rise_edge u_bonus_edge (.clk(clk), .rst(rst), .i_level(bus.bonus), .o_pulse(w_bonus));

  game_state_t        r_state;
  game_state_t        w_state_nx;
  logic [LIFE_W-1:0]  r_life;
  logic [LIFE_W-1:0]  w_life_nx;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_nx;
  logic [BLINK_W-1:0] r_bcnt;
  logic [BLINK_W-1:0] w_bcnt_nx;
  logic               r_blink;
  logic               w_blink_nx;
  logic               r_game_over;
  logic               r_invuln;

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_life      <= LIFE_W'(0);
      r_timer     <= TIMER_W'(0);
      r_bcnt      <= BLINK_W'(0);
      r_blink     <= 1'b0;
      r_game_over <= 1'b0;
      r_invuln    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_life      <= w_life_nx;
      r_timer     <= w_timer_nx;
      r_bcnt      <= w_bcnt_nx;
      r_blink     <= w_blink_nx;
      r_game_over <= (w_state_nx == GAME_OVER);
      r_invuln    <= (w_state_nx == INVULN);
    end
  end

  // Next-state logic; blink and its counter fall to zero unless staying in INVULN.
  always_comb begin
    w_state_nx = r_state;
    w_life_nx  = r_life;
    w_timer_nx = r_timer;
    w_blink_nx = 1'b0;
    w_bcnt_nx  = BLINK_W'(0);
    case (r_state)
      IDLE, GAME_OVER: begin
        if (w_start) begin
          w_state_nx = PLAY;
          w_life_nx  = LIFE_INIT;
        end else begin
          w_state_nx = r_state;
        end
      end
      PLAY: begin
        if (w_hit && w_bonus) begin
          w_state_nx = INVULN;
          w_timer_nx = TIMER_LOAD;
          w_blink_nx = 1'b1;
        end else if (w_hit) begin
          if (r_life > LIFE_W'(1)) begin
            w_life_nx  = r_life - LIFE_W'(1);
            w_state_nx = INVULN;
            w_timer_nx = TIMER_LOAD;
            w_blink_nx = 1'b1;
          end else begin
            w_life_nx  = LIFE_W'(0);
            w_state_nx = GAME_OVER;
          end
        end else if (w_bonus) begin
          w_life_nx = sat_inc(r_life, LIFE_CEIL);
        end else begin
          w_life_nx = r_life;
        end
      end
      INVULN: begin
        if (w_bonus) begin
          w_life_nx = sat_inc(r_life, LIFE_CEIL);
        end else begin
          w_life_nx = r_life;
        end
        if (r_timer == TIMER_W'(0)) begin
          w_state_nx = PLAY;
          w_timer_nx = TIMER_W'(0);
        end else begin
          w_timer_nx = r_timer - TIMER_W'(1);
          if (r_bcnt == BLINK_LAST) begin
            w_blink_nx = ~r_blink;
            w_bcnt_nx  = BLINK_W'(0);
          end else begin
            w_blink_nx = r_blink;
            w_bcnt_nx  = r_bcnt + BLINK_W'(1);
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_life_nx  = LIFE_W'(0);
        w_timer_nx = TIMER_W'(0);
      end
    endcase
  end

  assign bus.life         = r_life;
  assign bus.game_over    = r_game_over;
  assign bus.invulnerable = r_invuln;
  assign bus.blink        = r_blink;

endmodule

// File: tb/tb_life_tracker.sv
// Self-checking bench for life_tracker: directed scenarios plus random
// stimulus, all compared against a cycle-level game model.
module tb_life_tracker;

  localparam int INIT_L = 3;
  localparam int MAX_L  = 9;
  localparam int INV_N  = 10;
  localparam int BH     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  life_tracker_if bus();

  life_tracker #(
    .INIT_LIFE(INIT_L), .MAX_LIFE(MAX_L), .INVULN_CYCLES(INV_N), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [6:0] dut_vec;
  assign dut_vec = {bus.life, bus.game_over, bus.invulnerable, bus.blink};

  // Game model: mode 0 idle, 1 play, 2 invulnerable, 3 game over.
  int m_mode, m_life, m_elapsed;
  bit m_ps, m_ph, m_pb;

  function automatic void model_reset();
    m_mode = 0; m_life = 0; m_elapsed = 0;
    m_ps = 1'b1; m_ph = 1'b1; m_pb = 1'b1;
  endfunction

  function automatic void model_step();
    bit se, he, be;
    se = bus.start && !m_ps;
    he = bus.hit   && !m_ph;
    be = bus.bonus && !m_pb;
    m_ps = bus.start; m_ph = bus.hit; m_pb = bus.bonus;
    case (m_mode)
      0, 3: if (se) begin m_mode = 1; m_life = INIT_L; end
      1: begin
        if (he && be) begin
          m_mode = 2; m_elapsed = 0;
        end else if (he) begin
          if (m_life > 1) begin m_life = m_life - 1; m_mode = 2; m_elapsed = 0; end
          else begin m_life = 0; m_mode = 3; end
        end else if (be) begin
          m_life = (m_life < MAX_L) ? m_life + 1 : MAX_L;
        end
      end
      2: begin
        if (be) m_life = (m_life < MAX_L) ? m_life + 1 : MAX_L;
        if (m_elapsed == INV_N - 1) m_mode = 1;
        else m_elapsed = m_elapsed + 1;
      end
      default: m_mode = 0;
    endcase
  endfunction

  function automatic logic [6:0] model_vec();
    logic bl;
    bl = (m_mode == 2) && (((m_elapsed / BH) % 2) == 0);
    return {4'(m_life), (m_mode == 3), (m_mode == 2), bl};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    cyc++;
  endtask

  task automatic drive(input logic s, input logic h, input logic b);
    bus.start = s; bus.hit = h; bus.bonus = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (3) tick();
    checks++;
    if (dut_vec !== 7'b0) begin
      errors++; $display("FAIL reset_state: got %b expected %b", dut_vec, 7'b0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++; $display("FAIL reset_release: got %b expected %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_start_hold();
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL start_hold cyc %0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.life !== 4'd3 || bus.game_over !== 1'b0 || bus.invulnerable !== 1'b0) begin
      errors++; $display("FAIL start_single_load: got life=%0d go=%b inv=%b expected life=3 go=0 inv=0",
                         bus.life, bus.game_over, bus.invulnerable);
    end
  endtask

  task automatic test_invuln();
    int cnt;
    drive(1'b0, 1'b1, 1'b0);
    tick();
    cnt = int'(bus.invulnerable);
    checks++;
    if (bus.life !== 4'd2 || bus.invulnerable !== 1'b1) begin
      errors++; $display("FAIL hit_entry: got life=%0d inv=%b expected life=2 inv=1", bus.life, bus.invulnerable);
    end
    for (int i = 1; i <= 13; i++) begin
      drive(1'b0, (i == 3), 1'b0);
      tick();
      cnt += int'(bus.invulnerable);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL invuln_window cyc %0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt != INV_N || bus.life !== 4'd2) begin
      errors++; $display("FAIL invuln_length: got cycles=%0d life=%0d expected cycles=%0d life=2", cnt, bus.life, INV_N);
    end
  endtask

  task automatic test_game_over();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++; $display("FAIL life1_play: got %b expected %b", dut_vec, model_vec());
    end
    drive(1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus.life !== 4'd0 || bus.game_over !== 1'b1) begin
      errors++; $display("FAIL last_hit: got life=%0d go=%b expected life=0 go=1", bus.life, bus.game_over);
    end
    drive(1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1);
    tick();
    tick();
    checks++;
    if (bus.life !== 4'd0 || bus.game_over !== 1'b1 || dut_vec !== model_vec()) begin
      errors++; $display("FAIL over_ignores: got %b expected %b", dut_vec, model_vec());
    end
    drive(1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.life !== 4'd3 || bus.game_over !== 1'b0) begin
      errors++; $display("FAIL restart: got life=%0d go=%b expected life=3 go=0", bus.life, bus.game_over);
    end
    drive(1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL bonus_step %0d: got %b expected %b", k, dut_vec, model_vec());
      end
    end
    checks++;
    if (bus.life !== 4'd9) begin
      errors++; $display("FAIL saturation: got life=%0d expected life=9", bus.life);
    end
  endtask

  task automatic test_simul_and_blink();
    logic [9:0] pat;
    pat = 10'b1100110011;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    drive(1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    drive(1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.life !== 4'd2 || bus.invulnerable !== 1'b1 || bus.blink !== pat[0]) begin
      errors++; $display("FAIL simul_hit_bonus: got life=%0d inv=%b blink=%b expected life=2 inv=1 blink=%b",
                         bus.life, bus.invulnerable, bus.blink, pat[0]);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (bus.blink !== pat[i] || bus.invulnerable !== 1'b1 || dut_vec !== model_vec()) begin
        errors++; $display("FAIL blink_pattern cyc %0d: got %b expected %b blink=%b", i, dut_vec, model_vec(), pat[i]);
      end
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 7'b0) begin
      errors++; $display("FAIL async_reset: got %b expected %b", dut_vec, 7'b0);
    end
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1);
    tick();
    tick();
    checks++;
    if (dut_vec !== 7'b0 || dut_vec !== model_vec()) begin
      errors++; $display("FAIL post_reset_idle: got %b expected %b", dut_vec, 7'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_held_over_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.life !== 4'd0 || dut_vec !== model_vec()) begin
      errors++; $display("FAIL held_start_no_edge: got %b expected %b", dut_vec, model_vec());
    end
    drive(1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (bus.life !== 4'd3) begin
      errors++; $display("FAIL start_after_low: got life=%0d expected life=3", bus.life);
    end
    drive(1'b0, 1'b0, 1'b0); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 15) == 0) ? ~bus.start : bus.start,
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0));
      rst = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %b expected %b", cyc, dut_vec, model_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    test_reset();
    test_start_hold();
    test_invuln();
    test_game_over();
    test_saturation();
    test_simul_and_blink();
    test_start_held_over_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/life_tracker.md
LIFE_TRACKER -- requirements
Module: life_tracker

Interface
REQ-001 SHALL have parameter INIT_LIFE, default 3: life loaded on game start; legal range 1..MAX_LIFE.
REQ-002 SHALL have parameter MAX_LIFE, default 9: saturation ceiling, so life always fits one 7-seg digit (0..9).
REQ-003 SHALL have parameter INVULN_CYCLES, default 50_000_000: invulnerability window after a hit, in clk cycles; must be >= 2.
REQ-004 SHALL have parameter BLINK_HALF, default 6_250_000: blink half-period, in clk cycles; must be >= 1.
REQ-005 SHALL have port clk  input  1: single system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1: new-game request, level input; acts on its rising edge.
REQ-008 SHALL have port hit  input  1: player-hit request, level input; acts on its rising edge.
REQ-009 SHALL have port bonus  input  1: extra-life request, level input; acts on its rising edge.
REQ-010 SHALL have port life  output  4: current life count, drives the life seven-segment writer.
REQ-011 SHALL have port game_over  output  1: high while in GAME_OVER.
REQ-012 SHALL have port invulnerable  output  1: high while in INVULN.
REQ-013 SHALL have port blink  output  1: display-blank request; toggles during INVULN, 0 otherwise.

Function
REQ-014 SHALL detect each input's rising edge as input(t)=1 AND a registered copy from t-1 = 0; a held level SHALL act exactly once.
REQ-015 SHALL implement FSM states IDLE, PLAY, INVULN, GAME_OVER.
REQ-016 SHALL, in IDLE or GAME_OVER on a start edge, enter PLAY, load life=INIT_LIFE and clear game_over.
REQ-017 SHALL ignore start edges while in PLAY or INVULN.
REQ-018 SHALL, in PLAY on a hit edge with life>1, decrement life, enter INVULN and load the timer with INVULN_CYCLES-1.
REQ-019 SHALL, in PLAY on a hit edge with life==1, set life=0 and enter GAME_OVER.
REQ-020 SHALL, in PLAY or INVULN on a bonus edge, increment life, saturating at MAX_LIFE.
REQ-021 SHALL, in PLAY on simultaneous hit and bonus edges, leave life unchanged and enter INVULN.
REQ-022 SHALL ignore hit edges while in INVULN.
REQ-023 SHALL, in INVULN, decrement the timer every cycle and enter PLAY in the cycle after the timer reads 0.
REQ-024 SHALL ignore hit and bonus edges while in IDLE or GAME_OVER.
REQ-025 SHALL ensure life never underflows below 0 and never exceeds MAX_LIFE.
REQ-026 SHALL drive blink=1 on INVULN entry, invert it every BLINK_HALF cycles, and force it to 0 outside INVULN.
REQ-027 SHALL register all outputs: the response appears on outputs one clk after the cycle in which the edge is detected.

Reset
REQ-028 SHALL, while rst=1 and independent of clk, force: state=IDLE, life=0, game_over=0, invulnerable=0, blink=0, timer=0, blink counter=0, edge registers=0.
REQ-029 SHALL, on rst asserted mid-INVULN or mid-GAME_OVER, abandon the state with no residual timer or blink effect.
REQ-030 SHALL, after rst release, hold a start input that is already high as not-an-edge until it has been seen low.

Structure
REQ-031 SHALL take the state encoding (IDLE, PLAY, INVULN, GAME_OVER) and the constant LIFE_W=4 from the shared game package.
REQ-032 SHALL instantiate a sub-module rise_edge (one clk, rst, level in, one-cycle pulse out) once each for start, hit and bonus.
REQ-033 SHALL size the timer and blink counters with $clog2 of their parameters.

Verification
REQ-034 SHALL cover: reset, start high for 5 cycles -> life=3 one cycle after the edge, game state PLAY, a single load only.
REQ-035 SHALL cover, with INVULN_CYCLES=10: hit in PLAY -> life 3->2, invulnerable=1 for exactly 10 cycles; a second hit during that window -> life stays 2.
REQ-036 SHALL cover: from life=1, hit -> life=0 and game_over=1; then hit and bonus -> no change; then start -> life=3 and game_over=0.
REQ-037 SHALL cover: 8 bonus edges from life=3 -> life saturates at 9.
REQ-038 SHALL cover: simultaneous hit and bonus edges at life=2 -> life=2 and invulnerable=1.
REQ-039 SHALL cover, with BLINK_HALF=2: blink pattern 1,1,0,0,1,1... throughout INVULN; rst pulsed mid-INVULN -> all outputs 0 immediately.
